// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash read responder.
// States, the read opcode and SPI bit-count widths live here.
package spi_flash_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      FETCH,
      DATA,
      IGNORE
   } state_t;

   localparam logic [7:0] CMD_READ = 8'h03;
   localparam int CMD_BITS = 8;
   localparam int BYTE_BITS = 8;
   localparam int CNT_W = 6;

   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t CNT_ONE = cnt_t'(1);

endpackage

// File: rtl/spi_edge_sync.sv
// Brings the SPI pins into the clock domain and detects sck/ss edges.
// ss falling is held off until the chain has flushed after reset.
module spi_edge_sync
   import spi_flash_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic spi_sck,
   input  logic spi_ss,
   input  logic spi_mosi,
   output logic sck_rise,
   output logic sck_fall,
   output logic ss_rise,
   output logic ss_fall,
   output logic mosi
);

   localparam int MSB = SYNC_STAGES - 1;

   logic [MSB:0] sck_q;
   logic [MSB:0] ss_q;
   logic [MSB:0] mosi_q;
   logic         sck_d;
   logic         ss_d;
   logic [SYNC_STAGES:0] warm;

   always_ff @(posedge clock) begin
      if (reset) begin
         sck_q  <= '0;
         ss_q   <= '1;
         mosi_q <= '0;
         sck_d  <= 1'b0;
         ss_d   <= 1'b1;
         warm   <= '0;
      end else begin
         sck_q  <= {sck_q[SYNC_STAGES-2:0], spi_sck};
         ss_q   <= {ss_q[SYNC_STAGES-2:0], spi_ss};
         mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
         sck_d  <= sck_q[MSB];
         ss_d   <= ss_q[MSB];
         warm   <= {warm[SYNC_STAGES-1:0], 1'b1};
      end
   end

   // A select held low through reset must not look like a new frame.
   assign ss_fall  = warm[SYNC_STAGES] & ss_d & ~ss_q[MSB];
   assign ss_rise  = ss_q[MSB] & ~ss_d;
   assign sck_rise = sck_q[MSB] & ~sck_d;
   assign sck_fall = ~sck_q[MSB] & sck_d;
   assign mosi     = mosi_q[MSB];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 responder for the 0x03 read command, streaming bytes
// from a 32-bit little-endian word store with next-word fetch.
module spi_flash_responder
   import spi_flash_pkg::*;
#(
   parameter int ADDR_W = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              spi_sck,
   input  logic              spi_ss,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              mem_ren,
   output logic [ADDR_W-3:0] mem_raddr,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_rvalid,
   output logic              cmd_err,
   output logic              underrun
);

   logic sck_rise;
   logic sck_fall;
   logic ss_rise;
   logic ss_fall;
   logic mosi;

   spi_edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clock   (clock),
      .reset   (reset),
      .spi_sck (spi_sck),
      .spi_ss  (spi_ss),
      .spi_mosi(spi_mosi),
      .sck_rise(sck_rise),
      .sck_fall(sck_fall),
      .ss_rise (ss_rise),
      .ss_fall (ss_fall),
      .mosi    (mosi)
   );

   state_t            state;
   cnt_t              bit_cnt;
   logic [6:0]        cmd;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       word;
   logic              pending;
   logic              stale;

   logic [7:0]        cmd_shift;
   logic [ADDR_W-1:0] addr_shift;
   logic [ADDR_W-1:0] addr_inc;
   logic [4:0]        bit_sel;
   logic              data_fall;

   assign cmd_shift  = {cmd, mosi};
   assign addr_shift = {addr[ADDR_W-2:0], mosi};
   assign addr_inc   = addr + ADDR_W'(1);
   assign bit_sel    = {addr[1:0], ~bit_cnt[2:0]};
   assign data_fall  = sck_fall & ~ss_rise
                     & ((state == FETCH) | (state == DATA));

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         cmd       <= '0;
         addr      <= '0;
         word      <= '0;
         pending   <= 1'b0;
         stale     <= 1'b0;
         spi_miso  <= 1'b1;
         mem_ren   <= 1'b0;
         mem_raddr <= '0;
         cmd_err   <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         mem_ren  <= 1'b0;
         cmd_err  <= 1'b0;
         underrun <= 1'b0;
         if (mem_rvalid) begin
            pending <= 1'b0;
            stale   <= 1'b0;
         end
         if (ss_rise) begin
            state    <= IDLE;
            spi_miso <= 1'b1;
         end else begin
            unique case (state)
               IDLE: begin
                  spi_miso <= 1'b1;
                  if (ss_fall) begin
                     state   <= CMD;
                     bit_cnt <= '0;
                  end
               end
               CMD: if (sck_rise) begin
                  cmd     <= cmd_shift[6:0];
                  bit_cnt <= bit_cnt + CNT_ONE;
                  if (bit_cnt == cnt_t'(CMD_BITS - 1)) begin
                     bit_cnt <= '0;
                     if (cmd_shift == CMD_READ) begin
                        state <= ADDR;
                     end else begin
                        state   <= IGNORE;
                        cmd_err <= 1'b1;
                     end
                  end
               end
               ADDR: if (sck_rise) begin
                  addr    <= addr_shift;
                  bit_cnt <= bit_cnt + CNT_ONE;
                  if (bit_cnt == cnt_t'(ADDR_W - 1)) begin
                     bit_cnt   <= '0;
                     state     <= FETCH;
                     mem_ren   <= 1'b1;
                     mem_raddr <= addr_shift[ADDR_W-1:2];
                     pending   <= 1'b1;
                  end
               end
               FETCH: if (mem_rvalid) begin
                  // A late reply for a word already passed is refetched.
                  if (stale) begin
                     mem_ren   <= 1'b1;
                     mem_raddr <= addr[ADDR_W-1:2];
                     pending   <= 1'b1;
                  end else begin
                     word  <= mem_rdata;
                     state <= DATA;
                  end
               end
               default: ;
            endcase
            if (data_fall) begin
               if (state == DATA) begin
                  spi_miso <= word[bit_sel];
               end else begin
                  spi_miso <= 1'b1;
                  underrun <= 1'b1;
               end
               bit_cnt <= bit_cnt + CNT_ONE;
               if (bit_cnt[2:0] == 3'(BYTE_BITS - 1)) begin
                  bit_cnt <= '0;
                  addr    <= addr_inc;
                  if (addr[1:0] == 2'd3) begin
                     state <= FETCH;
                     if (!pending || mem_rvalid) begin
                        mem_ren   <= 1'b1;
                        mem_raddr <= addr_inc[ADDR_W-1:2];
                        pending   <= 1'b1;
                        stale     <= 1'b0;
                     end else begin
                        stale <= 1'b1;
                     end
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: SPI master, word store and a
// byte-level reference of the read stream and fetch sequence.
module tb_spi_flash_responder;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        spi_sck = 1'b0;
   logic        spi_ss = 1'b1;
   logic        spi_mosi = 1'b0;
   logic        spi_miso;
   logic        mem_ren;
   logic [21:0] mem_raddr;
   logic [31:0] mem_rdata = '0;
   logic        mem_rvalid = 1'b0;
   logic        cmd_err;
   logic        underrun;

   always #5 clock = ~clock;

   spi_flash_responder #(
      .ADDR_W(24),
      .SYNC_STAGES(2)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .spi_sck   (spi_sck),
      .spi_ss    (spi_ss),
      .spi_mosi  (spi_mosi),
      .spi_miso  (spi_miso),
      .mem_ren   (mem_ren),
      .mem_raddr (mem_raddr),
      .mem_rdata (mem_rdata),
      .mem_rvalid(mem_rvalid),
      .cmd_err   (cmd_err),
      .underrun  (underrun)
   );

   typedef struct {
      logic [7:0]  cmd;
      logic [23:0] addr;
      int          ndata;
      int          half;
      int          exp_err;
      int          exp_under;
   } vec_t;

   int          n_checks = 0;
   int          n_fail = 0;
   int          err_cnt = 0;
   int          un_cnt = 0;
   int          first_delay = 0;
   logic [21:0] ren_log[$];
   bit          samp_q[$];

   function automatic logic [31:0] mem_word(input logic [21:0] w);
      if (w == 22'd1) return 32'h4433_2211;
      return (32'(w) * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
   endfunction

   function automatic logic [7:0] mem_byte(input logic [23:0] a);
      logic [31:0] w;
      w = mem_word(a[23:2]);
      return w[int'(a[1:0]) * 8 +: 8];
   endfunction

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   always @(negedge clock) begin
      if (cmd_err) err_cnt++;
      if (underrun) un_cnt++;
      if (mem_ren) ren_log.push_back(mem_raddr);
   end

   // Word store: answers each request after 1..4 cycles (or a forced delay).
   initial begin
      int d;
      logic [21:0] a;
      forever begin
         @(negedge clock);
         mem_rvalid = 1'b0;
         if (mem_ren) begin
            a = mem_raddr;
            d = (first_delay > 0) ? first_delay
                                  : int'($urandom_range(1, 4));
            first_delay = 0;
            repeat (d - 1) @(negedge clock);
            mem_rdata  = mem_word(a);
            mem_rvalid = 1'b1;
         end
      end
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic spi_bits(input logic [31:0] val, input int n,
                           input int half);
      for (int i = n - 1; i >= 0; i--) begin
         spi_mosi = val[i];
         #(half * 10);
         spi_sck = 1'b1;
         samp_q.push_back(spi_miso);
         #(half * 10);
         spi_sck = 1'b0;
      end
   endtask

   task automatic spi_xfer(input logic [7:0] cmd, input logic [23:0] addr,
                           input int ndata, input int half);
      int rem;
      int n;
      samp_q.delete();
      ren_log.delete();
      err_cnt = 0;
      un_cnt  = 0;
      @(negedge clock);
      spi_ss = 1'b0;
      #(half * 10);
      spi_bits(32'(cmd), 8, half);
      spi_bits(32'(addr), 24, half);
      rem = ndata;
      while (rem > 0) begin
         n = (rem > 32) ? 32 : rem;
         spi_bits($urandom, n, half);
         rem -= n;
      end
      #(half * 10);
      spi_ss = 1'b1;
      #400;
   endtask

   // Reference: bit j of the stream is bit 7-(j%8) of byte addr+j/8; the
   // first `skip` bits are forced to 1. The master's closing sck fall also
   // shifts out bit ndata, so a word ending there still triggers a fetch.
   task automatic verify(input int id, input logic [7:0] cmd,
                         input logic [23:0] addr, input int ndata,
                         input int exp_err, input int exp_under,
                         input int skip);
      int          bad;
      int          n;
      int          j;
      int          nidle;
      logic [7:0]  eb;
      logic [23:0] a;
      logic [31:0] got;
      logic [31:0] exp;
      logic [21:0] exp_ren[$];
      string       tag;
      tag   = $sformatf("v%0d", id);
      nidle = (cmd == 8'h03) ? 32 : 32 + ndata;
      bad   = 0;
      for (int i = 0; i < nidle && i < samp_q.size(); i++)
         if (samp_q[i] !== 1'b1) bad++;
      check({tag, " miso_idle_bits"}, bad, 0);
      check({tag, " cmd_err"}, err_cnt, exp_err);
      check({tag, " nsamples"}, samp_q.size(), 32 + ndata);
      if (exp_under >= 0)
         check({tag, " underrun"}, un_cnt, exp_under);
      if (cmd != 8'h03) begin
         check({tag, " ren_count"}, ren_log.size(), 0);
         return;
      end
      for (int b = 0; b * 8 < ndata; b++) begin
         n   = (ndata - b * 8 > 8) ? 8 : ndata - b * 8;
         got = '0;
         exp = '0;
         eb  = mem_byte(addr + 24'(b));
         for (int k = 0; k < n; k++) begin
            j   = b * 8 + k;
            got = {got[30:0], (32 + j < samp_q.size()) ? samp_q[32 + j]
                                                       : 1'b0};
            exp = {exp[30:0], (j < skip) ? 1'b1 : eb[7 - k]};
         end
         check($sformatf("%s byte%0d", tag, b), got, exp);
      end
      exp_ren.push_back(addr[23:2]);
      for (int jj = 0; jj <= ndata; jj++) begin
         a = addr + 24'(jj / 8);
         if (jj % 8 == 7 && a[1:0] == 2'd3) begin
            a = a + 24'd1;
            exp_ren.push_back(a[23:2]);
         end
      end
      check({tag, " ren_count"}, ren_log.size(), exp_ren.size());
      for (int i = 0; i < exp_ren.size() && i < ren_log.size(); i++)
         check($sformatf("%s raddr%0d", tag, i), ren_log[i], exp_ren[i]);
   endtask

   initial begin
      vec_t        tbl[7];
      int          u;
      int          bad;
      logic [23:0] ra;
      int          nd;
      int          hf;

      tbl[0] = '{8'h03, 24'h000004, 32, 8, 0, 0};
      tbl[1] = '{8'h03, 24'h000006, 48, 8, 0, 0};
      tbl[2] = '{8'h0B, 24'h000000, 16, 8, 1, 0};
      tbl[3] = '{8'h03, 24'h000010, 24, 9, 0, 0};
      tbl[4] = '{8'h03, 24'hFFFFFC, 64, 8, 0, 0};
      tbl[5] = '{8'h03, 24'h000002, 12, 10, 0, 0};
      tbl[6] = '{8'h9F, 24'h123456, 8, 8, 1, 0};

      repeat (4) @(negedge clock);
      check("rst miso", spi_miso, 1);
      check("rst mem_ren", mem_ren, 0);
      check("rst mem_raddr", mem_raddr, 0);
      check("rst cmd_err", cmd_err, 0);
      check("rst underrun", underrun, 0);
      reset = 1'b0;
      repeat (5) @(negedge clock);

      for (int i = 0; i < 7; i++) begin
         spi_xfer(tbl[i].cmd, tbl[i].addr, tbl[i].ndata, tbl[i].half);
         verify(i, tbl[i].cmd, tbl[i].addr, tbl[i].ndata,
                tbl[i].exp_err, tbl[i].exp_under, 0);
      end

      // Late first word: leading bits come out as 1 with underrun pulses.
      first_delay = 40;
      spi_xfer(8'h03, 24'h000100, 32, 8);
      u = un_cnt;
      check("ur pulses_2_to_3", 32'((u >= 2) && (u <= 3)), 1);
      verify(10, 8'h03, 24'h000100, 32, 0, -1, u);

      // Reset in the middle of the address phase with ss still low.
      samp_q.delete();
      ren_log.delete();
      err_cnt = 0;
      @(negedge clock);
      spi_ss = 1'b0;
      #80;
      spi_bits(32'h03, 8, 8);
      spi_bits(32'h012, 10, 8);
      @(negedge clock);
      reset = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("midrst miso", spi_miso, 1);
      samp_q.delete();
      spi_bits(32'h3456, 14, 8);
      spi_bits(32'h0300_0000, 32, 8);
      bad = 0;
      foreach (samp_q[i]) if (samp_q[i] !== 1'b1) bad++;
      check("midrst miso_bits", bad, 0);
      check("midrst ren", ren_log.size(), 0);
      check("midrst cmd_err", err_cnt, 0);
      #80;
      spi_ss = 1'b1;
      #400;
      spi_xfer(8'h03, 24'h000005, 40, 8);
      verify(11, 8'h03, 24'h000005, 40, 0, 0, 0);

      for (int i = 0; i < 10; i++) begin
         ra = 24'($urandom);
         if ($urandom_range(0, 2) == 0)
            ra = 24'hFFFFF0 | 24'($urandom_range(0, 15));
         nd = int'($urandom_range(8, 72));
         hf = int'($urandom_range(8, 11));
         spi_xfer(8'h03, ra, nd, hf);
         verify(20 + i, 8'h03, ra, nd, 0, 0, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
